// File: rtl/enigma_encryptor.sv
// Three-rotor Enigma cipher engine (UKW-B reflector, no rings, no plugboard).
// One character per 10 cycles over a valid/ready handshake; rotors step odometer-style.
module enigma_encryptor #(
    parameter int ROTOR_L = 1,
    parameter int ROTOR_M = 2,
    parameter int ROTOR_R = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_key,
    input  logic [4:0] key_l,
    input  logic [4:0] key_m,
    input  logic [4:0] key_r,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] char_in,
    output logic       out_valid,
    output logic [7:0] char_out,
    output logic [4:0] pos_l,
    output logic [4:0] pos_m,
    output logic [4:0] pos_r
);

    localparam logic [207:0] WIRE_I   = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    localparam logic [207:0] WIRE_II  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    localparam logic [207:0] WIRE_III = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
    localparam logic [207:0] WIRE_UKW = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

    function automatic logic [207:0] rotor_table(input int sel);
        case (sel)
            2:       return WIRE_II;
            3:       return WIRE_III;
            default: return WIRE_I;
        endcase
    endfunction

    localparam logic [207:0] TBL_L = rotor_table(ROTOR_L);
    localparam logic [207:0] TBL_M = rotor_table(ROTOR_M);
    localparam logic [207:0] TBL_R = rotor_table(ROTOR_R);

    typedef enum logic [3:0] {
        IDLE, STEP, F_R, F_M, F_L, REFL, B_L, B_M, B_R, OUT
    } state_t;

    state_t     state, state_n;
    logic [4:0] c_q, stage_c;
    logic [7:0] char_q;
    logic       is_letter;
    logic       accept;

    // Operands are always < 26, so one conditional subtract replaces a modulo.
    function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'd26) s = s - 6'd26;
        return s[4:0];
    endfunction

    function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
        if (a >= b) return a - b;
        return 5'(6'd26 + {1'b0, a} - {1'b0, b});
    endfunction

    function automatic logic [4:0] inc26(input logic [4:0] a);
        return (a == 5'd25) ? 5'd0 : a + 5'd1;
    endfunction

    function automatic logic [4:0] red26(input logic [4:0] a);
        return (a >= 5'd26) ? a - 5'd26 : a;
    endfunction

    // Table entry idx (0 = leftmost character of the wiring string) as 0..25.
    function automatic logic [4:0] lookup(input logic [207:0] tbl, input logic [4:0] idx);
        logic [7:0] ch;
        ch = 8'h41;
        for (int unsigned k = 0; k < 26; k++)
            if (idx == k[4:0]) ch = tbl[8*(25-k) +: 8];
        return 5'(ch - 8'h41);
    endfunction

    // Position of letter idx within the wiring string (inverse permutation).
    function automatic logic [4:0] inverse(input logic [207:0] tbl, input logic [4:0] idx);
        logic [4:0] r;
        logic [7:0] target;
        r = '0;
        target = {3'b000, idx} + 8'h41;
        for (int unsigned k = 0; k < 26; k++)
            if (tbl[8*(25-k) +: 8] == target) r = k[4:0];
        return r;
    endfunction

    function automatic logic [4:0] fwd(input logic [207:0] tbl, input logic [4:0] p,
                                       input logic [4:0] c);
        return sub26(lookup(tbl, add26(c, p)), p);
    endfunction

    function automatic logic [4:0] bwd(input logic [207:0] tbl, input logic [4:0] p,
                                       input logic [4:0] c);
        return sub26(inverse(tbl, add26(c, p)), p);
    endfunction

    assign accept = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state sequencing and handshake outputs.
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !load_key;
                if (in_valid && !load_key) state_n = STEP;
            end
            STEP:    state_n = F_R;
            F_R:     state_n = F_M;
            F_M:     state_n = F_L;
            F_L:     state_n = REFL;
            REFL:    state_n = B_L;
            B_L:     state_n = B_M;
            B_M:     state_n = B_R;
            B_R:     state_n = OUT;
            OUT: begin
                out_valid = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // One rotor/reflector pass per cycle, selected by the current state.
    always_comb begin
        stage_c = c_q;
        case (state)
            F_R:     stage_c = fwd(TBL_R, pos_r, c_q);
            F_M:     stage_c = fwd(TBL_M, pos_m, c_q);
            F_L:     stage_c = fwd(TBL_L, pos_l, c_q);
            REFL:    stage_c = lookup(WIRE_UKW, c_q);
            B_L:     stage_c = bwd(TBL_L, pos_l, c_q);
            B_M:     stage_c = bwd(TBL_M, pos_m, c_q);
            B_R:     stage_c = bwd(TBL_R, pos_r, c_q);
            default: stage_c = c_q;
        endcase
    end

    // Rotor positions, working letter and result register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_l     <= '0;
            pos_m     <= '0;
            pos_r     <= '0;
            c_q       <= '0;
            char_q    <= '0;
            is_letter <= 1'b0;
            char_out  <= '0;
        end else begin
            if (state == IDLE && load_key) begin
                pos_l <= red26(key_l);
                pos_m <= red26(key_m);
                pos_r <= red26(key_r);
            end
            if (accept) begin
                char_q    <= char_in;
                c_q       <= 5'(char_in - 8'h41);
                is_letter <= (char_in >= 8'h41) && (char_in <= 8'h5A);
            end
            if (state == STEP && is_letter) begin
                pos_r <= inc26(pos_r);
                if (pos_r == 5'd25) begin
                    pos_m <= inc26(pos_m);
                    if (pos_m == 5'd25) pos_l <= inc26(pos_l);
                end
            end
            if (state inside {F_R, F_M, F_L, REFL, B_L, B_M})
                c_q <= stage_c;
            if (state == B_R)
                char_out <= is_letter ? ({3'b000, stage_c} + 8'h41) : char_q;
        end
    end

endmodule

// File: tb/tb_enigma_encryptor.sv
// Self-checking bench for enigma_encryptor: directed cases plus randomized
// characters/keys against a string-table Enigma reference model.
module tb_enigma_encryptor;

    localparam int RL = 1;
    localparam int RM = 2;
    localparam int RR = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_key = 1'b0;
    logic [4:0] key_l = '0, key_m = '0, key_r = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] char_in = '0;
    logic       out_valid;
    logic [7:0] char_out;
    logic [4:0] pos_l, pos_m, pos_r;

    int n_checks = 0;
    int n_fail = 0;
    int ml = 0, mm = 0, mr = 0;

    string rot[4] = '{"", "EKMFLGDQVZNTOWYHXUSPAIBRCJ", "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                      "BDFHJLCPRTXVZNYEIWGAKMUSQO"};
    string ukw = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

    enigma_encryptor #(.ROTOR_L(RL), .ROTOR_M(RM), .ROTOR_R(RR)) dut (
        .clk(clk), .reset(reset), .load_key(load_key),
        .key_l(key_l), .key_m(key_m), .key_r(key_r),
        .in_valid(in_valid), .in_ready(in_ready), .char_in(char_in),
        .out_valid(out_valid), .char_out(char_out),
        .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int mfwd(input string w, input int p, input int c);
        return ((int'(w[(c + p) % 26]) - 65) - p + 26) % 26;
    endfunction

    function automatic int minv(input string w, input int p, input int c);
        int j;
        j = 0;
        for (int i = 0; i < 26; i++)
            if (int'(w[i]) - 65 == (c + p) % 26) j = i;
        return (j - p + 26) % 26;
    endfunction

    task automatic model_char(input logic [7:0] ch, output logic [7:0] o);
        int c;
        if (ch >= 8'h41 && ch <= 8'h5A) begin
            mr = (mr + 1) % 26;
            if (mr == 0) begin
                mm = (mm + 1) % 26;
                if (mm == 0) ml = (ml + 1) % 26;
            end
            c = int'(ch) - 65;
            c = mfwd(rot[RR], mr, c);
            c = mfwd(rot[RM], mm, c);
            c = mfwd(rot[RL], ml, c);
            c = int'(ukw[c]) - 65;
            c = minv(rot[RL], ml, c);
            c = minv(rot[RM], mm, c);
            c = minv(rot[RR], mr, c);
            o = 8'(c + 65);
        end else begin
            o = ch;
        end
    endtask

    task automatic load(input int l, input int m, input int r);
        @(negedge clk);
        load_key = 1'b1;
        key_l = 5'(l); key_m = 5'(m); key_r = 5'(r);
        #1 check("in_ready_low_on_load", in_ready, 0);
        @(negedge clk);
        load_key = 1'b0;
        ml = l % 26; mm = m % 26; mr = r % 26;
        check("load_pos_l", pos_l, ml);
        check("load_pos_m", pos_m, mm);
        check("load_pos_r", pos_r, mr);
    endtask

    // kind: 0 plain, 1 load_key pulse while busy, 2 reset pulse during B_M.
    task automatic send(input logic [7:0] ch, input int kind, output logic [7:0] got,
                        output int lat, output int pulses);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        char_in = ch;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = -1;
        pulses = 0;
        got = 8'h00;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    got = char_out;
                end
            end
            load_key = (kind == 1 && k == 3);
            if (kind == 1 && k == 3) begin
                key_l = 5'($urandom_range(10, 20));
                key_m = 5'($urandom_range(10, 20));
                key_r = 5'($urandom_range(10, 20));
            end
            reset = !(kind == 2 && k == 7);
            if (kind != 2 && k >= 2 && k <= 8) begin
                in_valid = 1'b1;
                char_in = 8'($urandom_range(65, 90));
            end else begin
                in_valid = 1'b0;
            end
        end
        if (lat < 0) got = char_out;
    endtask

    task automatic run_char(input logic [7:0] ch, input int kind, output logic [7:0] got);
        logic [7:0] exp;
        int lat, pulses;
        model_char(ch, exp);
        send(ch, kind, got, lat, pulses);
        if (kind == 2) begin
            ml = 0; mm = 0; mr = 0;
            check("abort_no_pulse", pulses, 0);
            check("abort_char_out", char_out, 8'h00);
            check("abort_in_ready", in_ready, 1);
        end else begin
            check("char_out", got, exp);
            check("latency", lat, 9);
            check("single_pulse", pulses, 1);
        end
        check("pos_l", pos_l, ml);
        check("pos_m", pos_m, mm);
        check("pos_r", pos_r, mr);
    endtask

    initial begin
        logic [7:0] got;
        string      s1;
        string      s2;
        int         quiet;
        s1 = "BDZGO";
        s2 = "AAAAA";

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pos_l", pos_l, 0);
        check("rst_pos_m", pos_m, 0);
        check("rst_pos_r", pos_r, 0);
        check("rst_char_out", char_out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        reset = 1'b1;

        // Known vector and reciprocity
        load(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            run_char(8'h41, 0, got);
            check("vec_AAAAA", got, 8'(s1[i]));
        end
        check("vec_end_pos_r", pos_r, 5);
        load(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            run_char(8'(s1[i]), 0, got);
            check("vec_recip", got, 8'(s2[i]));
        end

        // Carry and full wrap
        load(0, 0, 25);
        run_char(8'h41, 0, got);
        check("carry_m", {pos_l, pos_m, pos_r}, {5'd0, 5'd1, 5'd0});
        load(25, 25, 25);
        run_char(8'h41, 0, got);
        check("full_wrap", {pos_l, pos_m, pos_r}, 15'd0);

        // Non-letters pass through without stepping
        load(4, 9, 13);
        run_char(8'h20, 0, got);
        check("space_pass", got, 8'h20);
        run_char(8'h61, 0, got);
        check("lower_pass", got, 8'h61);
        check("nonletter_pos", {pos_l, pos_m, pos_r}, {5'd4, 5'd9, 5'd13});

        // load_key beats in_valid; load_key ignored while busy
        @(negedge clk);
        load_key = 1'b1; in_valid = 1'b1; char_in = 8'h41;
        key_l = 5'd2; key_m = 5'd30; key_r = 5'd7;
        #1 check("ready_low_load_valid", in_ready, 0);
        @(negedge clk);
        load_key = 1'b0; in_valid = 1'b0;
        ml = 2; mm = 4; mr = 7;
        check("keyload_mod", {pos_l, pos_m, pos_r}, {5'd2, 5'd4, 5'd7});
        quiet = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid || !in_ready) quiet++;
        end
        check("no_capture_on_load", quiet, 0);
        run_char(8'h4B, 1, got);

        // Reset mid-flight
        load(3, 7, 11);
        run_char(8'h51, 2, got);
        run_char(8'h41, 0, got);

        // Randomized characters and keys
        for (int n = 0; n < 40; n++) begin
            logic [7:0] ch;
            if ($urandom_range(0, 7) == 0)
                load($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
            if ($urandom_range(0, 9) < 7) ch = 8'($urandom_range(65, 90));
            else                          ch = 8'($urandom);
            run_char(ch, 0, got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
